// File: rtl/i2s_tx_scheduler_if.sv
// Sample-buffer read side, refill request and I2S pins of i2s_tx_scheduler.
// master = buffer/system side, slave = scheduler side.
interface i2s_tx_scheduler_if #(
    parameter int WORD_W = 16,
    parameter int FILL_W = 7
);
    logic              enable;
    logic [FILL_W-1:0] fill_level;
    logic              sample_valid;
    logic [WORD_W-1:0] sample_data;
    logic              sample_req;
    logic              rpi_interrupt;
    logic              i2s_bclk;
    logic              i2s_lrclk;
    logic              i2s_sdata;
    logic [7:0]        underflow_count;
    logic              busy;

    modport master (
        output enable, fill_level, sample_valid, sample_data,
        input  sample_req, rpi_interrupt, i2s_bclk, i2s_lrclk,
        input  i2s_sdata, underflow_count, busy
    );

    modport slave (
        input  enable, fill_level, sample_valid, sample_data,
        output sample_req, rpi_interrupt, i2s_bclk, i2s_lrclk,
        output i2s_sdata, underflow_count, busy
    );
endinterface

// File: rtl/i2s_tx_scheduler.sv
// I2S playback scheduler: prefill, BCLK/LRCLK generation, MSB-first serialiser.
// Optional MONO_DUP_EN: one fetch per frame, same sample in both slots.
module i2s_tx_scheduler #(
    parameter int CLK_DIV    = 4,
    parameter int WORD_W     = 16,
    parameter int FILL_W     = 7,
    parameter int LOW_WATER  = 32,
    parameter int HIGH_WATER = 48
) (
    input logic               clk,
    input logic               rst,
    i2s_tx_scheduler_if.slave bus
);
    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int CNT_W = $clog2(WORD_W);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORD_W - 1);
    localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(WORD_W - 2);

    typedef enum logic [1:0] {IDLE, PREFILL, RUN} state_t;

    state_t            state_q, state_d;
    logic [DIV_W-1:0]  div_q;
    logic [CNT_W-1:0]  bit_cnt_q;
    logic              bclk_q, lrclk_q;
    logic [WORD_W-1:0] shift_q, hold_q;
    logic              req_q, req_d1_q, vld_d1_q;
    logic              stop_q, slot_q, irq_q;
    logic [7:0]        uf_q;
`ifdef MONO_DUP_EN
    logic [WORD_W-1:0] dup_q;
`endif

    logic tc, fall, load, done, issue, start, stopping;

    assign tc = (div_q == DIV_LAST);

    // Next state plus the per-cycle strobes for BCLK edge, slot load and fetch.
    always_comb begin
        state_d  = state_q;
        start    = 1'b0;
        fall     = 1'b0;
        load     = 1'b0;
        done     = 1'b0;
        issue    = 1'b0;
        stopping = stop_q | ~bus.enable;
        unique case (state_q)
            IDLE: begin
                if (bus.enable) state_d = PREFILL;
            end
            PREFILL: begin
                if (!bus.enable) begin
                    state_d = IDLE;
                end else if (bus.fill_level >= FILL_W'(HIGH_WATER)) begin
                    state_d = RUN;
                    start   = 1'b1;
                end
            end
            RUN: begin
                fall = tc & bclk_q;
                load = fall & (bit_cnt_q == CNT_LAST);
                // slot_q=1: a right slot just finished, so the frame is whole.
                done = load & slot_q & stopping;
`ifdef MONO_DUP_EN
                issue = load & ~lrclk_q & ~stopping;
`else
                issue = load & ~done & ~(lrclk_q & stopping);
`endif
                if (done) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Fetch handshake, hold register, underflow count and refill hysteresis.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_q    <= 1'b0;
            req_d1_q <= 1'b0;
            vld_d1_q <= 1'b0;
            hold_q   <= '0;
            uf_q     <= '0;
            irq_q    <= 1'b0;
        end else begin
            req_q    <= start | issue;
            req_d1_q <= req_q;
            if (req_q) vld_d1_q <= bus.sample_valid;
            if (req_d1_q) begin
                hold_q <= vld_d1_q ? bus.sample_data : '0;
                if (!vld_d1_q && uf_q != 8'hFF) uf_q <= uf_q + 8'd1;
            end
            if (bus.fill_level < FILL_W'(LOW_WATER))
                irq_q <= 1'b1;
            else if (bus.fill_level >= FILL_W'(HIGH_WATER))
                irq_q <= 1'b0;
        end
    end

    // Clock divider, bit/slot counters and serialiser; parked at 0 outside RUN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q     <= '0;
            bclk_q    <= 1'b0;
            lrclk_q   <= 1'b0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            slot_q    <= 1'b0;
            stop_q    <= 1'b0;
`ifdef MONO_DUP_EN
            dup_q     <= '0;
`endif
        end else if (state_q != RUN || done) begin
            div_q     <= '0;
            bclk_q    <= 1'b0;
            lrclk_q   <= 1'b0;
            bit_cnt_q <= start ? CNT_LAST : '0;
            shift_q   <= '0;
            slot_q    <= 1'b0;
            stop_q    <= 1'b0;
        end else begin
            div_q <= tc ? '0 : div_q + 1'b1;
            if (tc) bclk_q <= ~bclk_q;
            if (!bus.enable) stop_q <= 1'b1;
            if (fall) begin
                bit_cnt_q <= bit_cnt_q + 1'b1;
                if (bit_cnt_q == CNT_PRE) lrclk_q <= ~lrclk_q;
                if (load) begin
                    slot_q <= lrclk_q;
`ifdef MONO_DUP_EN
                    if (!lrclk_q) begin
                        shift_q <= hold_q;
                        dup_q   <= hold_q;
                    end else begin
                        shift_q <= dup_q;
                    end
`else
                    shift_q <= hold_q;
`endif
                end else begin
                    shift_q <= {shift_q[WORD_W-2:0], 1'b0};
                end
            end
        end
    end

    assign bus.sample_req      = req_q;
    assign bus.rpi_interrupt   = irq_q;
    assign bus.i2s_bclk        = bclk_q;
    assign bus.i2s_lrclk       = lrclk_q;
    assign bus.i2s_sdata       = shift_q[WORD_W-1];
    assign bus.underflow_count = uf_q;
    assign bus.busy            = (state_q != IDLE);
endmodule

// File: tb/tb_i2s_tx_scheduler.sv
// Directed bench for i2s_tx_scheduler: hysteresis table plus playback,
// underflow, stop, saturation and async-reset sequences.
`timescale 1ns/1ps
module tb_i2s_tx_scheduler;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    i2s_tx_scheduler_if #(.WORD_W(16), .FILL_W(7)) bus ();

    i2s_tx_scheduler #(
        .CLK_DIV(4), .WORD_W(16), .FILL_W(7),
        .LOW_WATER(32), .HIGH_WATER(48)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct packed {
        logic        lr;
        logic [15:0] w;
    } word_t;

    typedef struct {
        logic [6:0] fill;
        logic       irq;
    } hyst_vec_t;

    word_t       words[$];
    hyst_vec_t   vec[9];
    logic [15:0] pat[2];
    int          nreq = 0;
    int          pidx = 0;
    int          pass_n = 0;
    int          tot_n = 0;
    logic        mb_prev = 1'b0;
    logic        ml_prev = 1'b0;
    logic [15:0] msr = '0;

    // Buffer model and I2S receiver: data on req, bits captured on BCLK rise.
    always @(posedge clk) begin
        #1;
        if (rst) begin
            mb_prev = 1'b0;
            ml_prev = 1'b0;
            msr = '0;
        end else begin
            if (bus.sample_req) begin
                bus.sample_data = pat[pidx];
                pidx = (pidx + 1) % 2;
                nreq++;
            end
            if (bus.i2s_bclk && !mb_prev) begin
                msr = {msr[14:0], bus.i2s_sdata};
                if (bus.i2s_lrclk != ml_prev) words.push_back({ml_prev, msr});
                ml_prev = bus.i2s_lrclk;
            end
            mb_prev = bus.i2s_bclk;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tot_n++;
        if (act === exp) pass_n++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic word_t wd(input int i);
        if (i < words.size()) return words[i];
        return '1;
    endfunction

    task automatic wait_words(input int n, input int lim);
        int k = 0;
        while (words.size() < n && k < lim) begin
            tick();
            k++;
        end
        if (words.size() < n) chk("timeout_words", words.size(), n);
    endtask

    task automatic wait_nreq(input int n, input int lim);
        int k = 0;
        while (nreq < n && k < lim) begin
            tick();
            k++;
        end
        if (nreq < n) chk("timeout_nreq", nreq, n);
    endtask

    task automatic wait_idle(input int lim);
        int k = 0;
        while (bus.busy && k < lim) begin
            tick();
            k++;
        end
        if (bus.busy) chk("timeout_idle", 32'(bus.busy), 0);
    endtask

    initial begin
        int t, treq, tr1, tr2, nr1, k;
        logic bp;

        bus.enable = 1'b0;
        bus.fill_level = '0;
        bus.sample_valid = 1'b0;
        pat[0] = 16'hA5A5;
        pat[1] = 16'h5A5A;

        repeat (3) @(posedge clk);
        #2;
        chk("reset_outputs", 32'({bus.i2s_bclk, bus.i2s_lrclk, bus.i2s_sdata,
            bus.sample_req, bus.rpi_interrupt, bus.busy,
            bus.underflow_count}), 0);
        rst = 1'b0;
        tick();

        vec[0] = '{7'd50, 1'b0};
        vec[1] = '{7'd31, 1'b1};
        vec[2] = '{7'd40, 1'b1};
        vec[3] = '{7'd48, 1'b0};
        vec[4] = '{7'd40, 1'b0};
        vec[5] = '{7'd32, 1'b0};
        vec[6] = '{7'd20, 1'b1};
        vec[7] = '{7'd47, 1'b1};
        vec[8] = '{7'd63, 1'b0};
        for (int i = 0; i < 9; i++) begin
            bus.fill_level = vec[i].fill;
            tick();
            chk($sformatf("irq_vec%0d_fill%0d", i, vec[i].fill),
                32'(bus.rpi_interrupt), 32'(vec[i].irq));
        end

        bus.fill_level = 7'd10;
        bus.enable = 1'b1;
        tick();
        tick();
        chk("prefill_busy", 32'(bus.busy), 1);
        repeat (5) tick();
        chk("prefill_wait_no_req", nreq, 0);
        bus.enable = 1'b0;
        tick();
        chk("prefill_abort_idle", 32'(bus.busy), 0);

`ifdef MONO_DUP_EN
        pat[0] = 16'h1234;
        pat[1] = 16'h1234;
        bus.sample_valid = 1'b1;
        bus.fill_level = 7'd50;
        bus.enable = 1'b1;
        wait_words(4, 1200);
        chk("mono_req_per_frame", nreq, 3);
        for (int i = 0; i < 4; i++)
            chk($sformatf("mono_word%0d", i), 32'(wd(i)),
                32'({i[0], 16'h1234}));
        bus.enable = 1'b0;
        wait_idle(600);
        chk("mono_stop_idle", 32'(bus.busy), 0);
`else
        bus.sample_valid = 1'b1;
        bus.fill_level = 7'd50;
        bus.enable = 1'b1;
        t = 0; treq = -1; tr1 = -1; tr2 = -1; nr1 = -1; bp = 1'b0;
        while (tr2 < 0 && t < 200) begin
            tick();
            t++;
            if (bus.sample_req && treq < 0) treq = t;
            if (bus.i2s_bclk && !bp) begin
                if (tr1 < 0) begin
                    tr1 = t;
                    nr1 = nreq;
                end else begin
                    tr2 = t;
                end
            end
            bp = bus.i2s_bclk;
        end
        chk("prefill_one_req", nr1, 1);
        chk("first_rise_latency", tr1 - treq, 4);
        chk("bclk_period", tr2 - tr1, 8);

        wait_words(2, 600);
        chk("left_a5a5", 32'(wd(0)), 32'({1'b0, 16'hA5A5}));
        chk("right_5a5a", 32'(wd(1)), 32'({1'b1, 16'h5A5A}));

        bus.sample_valid = 1'b0;
        wait_nreq(5, 400);
        tick();
        bus.sample_valid = 1'b1;
        wait_words(6, 800);
        chk("uf_prev_left", 32'(wd(2)), 32'({1'b0, 16'hA5A5}));
        chk("uf_right_zero", 32'(wd(3)), 32'({1'b1, 16'h0000}));
        chk("uf_left_zero", 32'(wd(4)), 32'({1'b0, 16'h0000}));
        chk("uf_recover", 32'(wd(5)), 32'({1'b1, 16'h5A5A}));
        chk("uf_count_2", 32'(bus.underflow_count), 2);

        repeat (20) tick();
        bus.enable = 1'b0;
        wait_idle(600);
        chk("stop_req_count", nreq, 8);
        chk("stop_word_count", words.size(), 8);
        chk("stop_left", 32'(wd(6)), 32'({1'b0, 16'hA5A5}));
        chk("stop_right", 32'(wd(7)), 32'({1'b1, 16'h5A5A}));
        chk("stop_pins_zero", 32'({bus.i2s_bclk, bus.i2s_lrclk,
            bus.i2s_sdata}), 0);
        repeat (20) tick();
        chk("stop_stays_quiet", nreq, 8);

        bus.sample_valid = 1'b0;
        bus.enable = 1'b1;
        wait_nreq(308, 300 * 130 + 500);
        repeat (3) tick();
        chk("uf_saturate", 32'(bus.underflow_count), 255);

        k = 0;
        while (!bus.i2s_bclk && k < 20) begin
            tick();
            k++;
        end
        chk("bclk_high_before_rst", 32'(bus.i2s_bclk), 1);
        #1;
        rst = 1'b1;
        #1;
        chk("async_reset_outputs", 32'({bus.i2s_bclk, bus.i2s_lrclk,
            bus.i2s_sdata, bus.sample_req, bus.busy,
            bus.underflow_count}), 0);
        bus.enable = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        tick();
        chk("idle_after_rst", 32'(bus.busy), 0);
        chk("pins_after_rst", 32'({bus.i2s_bclk, bus.i2s_lrclk,
            bus.underflow_count}), 0);
`endif

        $display("%0d/%0d checks passed", pass_n, tot_n);
        $finish;
    end
endmodule
